// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for the FIFO stream reader blocks: occupancy encodings and default widths.
package fifo_stream_reader_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    localparam logic [1:0] OCC_0 = 2'd0;
    localparam logic [1:0] OCC_1 = 2'd1;
    localparam logic [1:0] OCC_2 = 2'd2;

    function automatic logic [1:0] occ_next(input logic [1:0] occ,
                                            input logic       push,
                                            input logic       pop);
        logic [1:0] r;
        r = occ;
        if (push && !pop) begin
            r = occ + 2'd1;
        end else if (pop && !push) begin
            r = occ - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_stream_skid.sv
// Two-entry in-order holding buffer; slot0 is always the oldest word.
module fifo_stream_skid
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [1:0]            occ_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
    logic [DATA_WIDTH-1:0] slot1_q, slot1_d;

    always_comb begin
        occ_d   = occ_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (en_i) begin
            occ_d = occ_next(occ_q, push_i, pop_i);
            unique case ({push_i, pop_i})
                2'b10: begin
                    if (occ_q == OCC_0) begin
                        slot0_d = push_data_i;
                    end else begin
                        slot1_d = push_data_i;
                    end
                end
                2'b01: slot0_d = slot1_q;
                // Simultaneous pop and capture: head leaves, new word lands behind any survivor.
                2'b11: begin
                    if (occ_q == OCC_2) begin
                        slot0_d = slot1_q;
                        slot1_d = push_data_i;
                    end else if (occ_q == OCC_1) begin
                        slot0_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q   <= OCC_0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            occ_q   <= occ_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = slot0_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Reader end of a FIFO with 1-cycle read latency, re-presented as a valid/ready stream.
// Optional words_sent counter enabled by defining STREAM_READER_STATS_EN.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
`ifdef STREAM_READER_STATS_EN
    ,
    parameter int unsigned CNT_WIDTH  = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef STREAM_READER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  words_sent
`endif
);

    logic       inflight_q, inflight_d;
    logic [1:0] occ;
    logic [1:0] pending;
    logic       take;
    logic       pop;

    assign out_valid = (occ != OCC_0);
    assign take      = out_valid & out_ready;
    assign pop       = clk_enable & take;
    assign pending   = occ + {1'b0, inflight_q};

    // A read may be issued into a full pipeline only when the head leaves on the same edge.
    assign fifo_read = !reset && !fifo_empty &&
                       ((pending < 2'd2) || ((pending == 2'd2) && take));

    assign inflight_d = clk_enable ? fifo_read : inflight_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_stream_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk_i       (clk),
        .rst_i       (reset),
        .en_i        (clk_enable),
        .push_i      (inflight_q),
        .push_data_i (fifo_read_data),
        .pop_i       (take),
        .occ_o       (occ),
        .head_o      (out_data)
    );

`ifdef STREAM_READER_STATS_EN
    logic [CNT_WIDTH-1:0] sent_q, sent_d;

    always_comb begin
        sent_d = sent_q;
        if (pop && (sent_q != '1)) begin
            sent_d = sent_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sent_q <= '0;
        end else begin
            sent_q <= sent_d;
        end
    end

    assign words_sent = sent_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: a small DEPTH=4 registered-read FIFO model feeding fifo_stream_reader.
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_enable;
    logic       fifo_empty;
    logic       fifo_read;
    logic [7:0] fifo_rdata;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
`ifdef STREAM_READER_STATS_EN
    logic [1:0] words_sent;
`endif

    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] fmem [4];
    logic [2:0] fcnt;
    logic [1:0] frp, fwp;
    logic       do_wr, do_rd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (fcnt == 3'd0);
    assign do_wr      = wr_en && (fcnt != 3'd4);
    assign do_rd      = fifo_read && (fcnt != 3'd0);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt       <= '0;
            frp        <= '0;
            fwp        <= '0;
            fifo_rdata <= '0;
        end else if (clk_enable) begin
            if (do_wr) begin
                fmem[fwp] <= wr_data;
                fwp       <= fwp + 2'd1;
            end
            if (do_rd) begin
                fifo_rdata <= fmem[frp];
                frp        <= frp + 2'd1;
            end
            fcnt <= fcnt + 3'(do_wr) - 3'(do_rd);
        end
    end

`ifdef STREAM_READER_STATS_EN
    fifo_stream_reader #(
        .DATA_WIDTH (8),
        .CNT_WIDTH  (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .fifo_empty     (fifo_empty),
        .fifo_read      (fifo_read),
        .fifo_read_data (fifo_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .words_sent     (words_sent)
    );
`else
    fifo_stream_reader #(
        .DATA_WIDTH (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .fifo_empty     (fifo_empty),
        .fifo_read      (fifo_read),
        .fifo_read_data (fifo_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clk_enable = 1'b1; wr_en = 1'b0; wr_data = '0; out_ready = 1'b0;
        #12;
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || fifo_read !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b data=%h read=%b, required 0/00/0", out_valid, out_data, fifo_read);
        end
        reset = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0 || fifo_read !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: valid=%b read=%b, required 0/0", out_valid, fifo_read);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp [3];
        exp = '{8'h11, 8'h22, 8'h33};
        out_ready = 1'b1; clk_enable = 1'b1;
        wr_en = 1'b1; wr_data = 8'h11;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL basic_lat_e0: valid=%b, required 0", out_valid);
        end
        wr_data = 8'h22;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL basic_lat_e1: valid=%b, required 0", out_valid);
        end
        wr_data = 8'h33;
        tick();
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                bad++;
                $display("FAIL basic_word%0d: valid=%b data=%h, required 1/%h", i, out_valid, out_data, exp[i]);
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL basic_drained: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; clk_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hA0 + i);
            tick();
            if (i == 1) begin
                total++;
                if (fifo_read !== 1'b1) begin
                    bad++; $display("FAIL bp_read_second: read=%b, required 1", fifo_read);
                end
            end
            if (i == 2) begin
                total++;
                if (fifo_read !== 1'b0) begin
                    bad++; $display("FAIL bp_read_drop: read=%b, required 0", fifo_read);
                end
            end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (fifo_read !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hA0) begin
                bad++;
                $display("FAIL bp_hold%0d: read=%b valid=%b data=%h, required 0/1/a0", i, fifo_read, out_valid, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (fifo_read !== 1'b1) begin
            bad++; $display("FAIL bp_ready_to_read: read=%b, required 1", fifo_read);
        end
        for (int i = 1; i < 4; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'(8'hA0 + i)) begin
                bad++;
                $display("FAIL bp_drain%0d: valid=%b data=%h, required 1/%h", i, out_valid, out_data, 8'(8'hA0 + i));
            end
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_drained: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_toggle_ready();
        logic [7:0] src [$];
        logic [7:0] got [$];
        logic       wrote;
        src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        clk_enable = 1'b1;
        for (int unsigned cyc = 0; cyc < 48; cyc++) begin
            out_ready = cyc[0];
            wr_en     = (src.size() > 0) && (fcnt < 3'd4);
            wr_data   = (src.size() > 0) ? src[0] : 8'h00;
            wrote     = wr_en;
            #1;
            if (out_valid && out_ready) got.push_back(out_data);
            tick();
            if (wrote) void'(src.pop_front());
        end
        wr_en = 1'b0;
        total++;
        if (got.size() != 8) begin
            bad++; $display("FAIL toggle_count: got %0d words, required 8", got.size());
        end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            total++;
            if (got[i] !== 8'(i + 1)) begin
                bad++; $display("FAIL toggle_order%0d: got %h, required %h", i, got[i], 8'(i + 1));
            end
        end
    endtask

    task automatic test_clk_enable();
        logic [7:0] src [$];
        logic [7:0] got [$];
        logic       wrote;
        logic       pv;
        logic [7:0] pd;
        src = '{8'h55, 8'h66};
        out_ready = 1'b1;
        for (int unsigned cyc = 0; cyc < 30; cyc++) begin
            clk_enable = (cyc % 3 == 0);
            wr_en      = (src.size() > 0) && (fcnt < 3'd4);
            wr_data    = (src.size() > 0) ? src[0] : 8'h00;
            wrote      = wr_en && clk_enable;
            #1;
            if (clk_enable && out_valid && out_ready) got.push_back(out_data);
            pv = out_valid; pd = out_data;
            tick();
            if (wrote) void'(src.pop_front());
            if (!clk_enable && cyc < 12) begin
                total++;
                if (out_valid !== pv || out_data !== pd) begin
                    bad++;
                    $display("FAIL en_frozen%0d: valid=%b data=%h, required %b/%h", cyc, out_valid, out_data, pv, pd);
                end
            end
        end
        clk_enable = 1'b1; wr_en = 1'b0;
        total++;
        if (got.size() != 2 || got[0] !== 8'h55 || got[1] !== 8'h66) begin
            bad++;
            $display("FAIL en_words: got %0d words first=%h, required 2 words 55,66", got.size(),
                     (got.size() > 0) ? got[0] : 8'h00);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; clk_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
            tick();
        end
        wr_en = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'hC0) begin
            bad++; $display("FAIL arst_pre: valid=%b data=%h, required 1/c0", out_valid, out_data);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || fifo_read !== 1'b0) begin
            bad++;
            $display("FAIL arst_immediate: valid=%b data=%h read=%b, required 0/00/0", out_valid, out_data, fifo_read);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL arst_discard%0d: valid=%b, required 0", i, out_valid);
            end
        end
    endtask

`ifdef STREAM_READER_STATS_EN
    task automatic test_stats();
        logic [7:0] src [$];
        logic       wrote;
        logic       popped;
        int         n;
        pulse_reset();
        total++;
        if (words_sent !== 2'd0) begin
            bad++; $display("FAIL stats_reset: words_sent=%0d, required 0", words_sent);
        end
        src = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        n = 0; out_ready = 1'b1; clk_enable = 1'b1;
        for (int unsigned cyc = 0; cyc < 20; cyc++) begin
            wr_en   = (src.size() > 0) && (fcnt < 3'd4);
            wr_data = (src.size() > 0) ? src[0] : 8'h00;
            wrote   = wr_en;
            #1;
            popped  = out_valid && out_ready;
            tick();
            if (wrote) void'(src.pop_front());
            if (popped) begin
                n++;
                total++;
                if (words_sent !== 2'((n > 3) ? 3 : n)) begin
                    bad++; $display("FAIL stats_count%0d: words_sent=%0d, required %0d", n, words_sent, (n > 3) ? 3 : n);
                end
            end
        end
        wr_en = 1'b0;
        total++;
        if (n != 5) begin
            bad++; $display("FAIL stats_pops: %0d pops, required 5", n);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_toggle_ready();
        test_clk_enable();
        test_async_reset();
`ifdef STREAM_READER_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
